// File: rtl/mac_mult_fetch_if.sv
// mac_mult_fetch_if: bundles the start/status, operand-memory read port and
// product output of mac_mult_fetch. The master modport is the fetch stage;
// the slave modport is its environment (controller, operand memories and the
// downstream mac_stop_accum).
interface mac_mult_fetch_if #(
  parameter int M                      = 4,
  parameter int K                      = 4,
  parameter int N                      = 4,
  parameter int DATA_WIDTH_INIT_MATRIX = 32
);
  localparam int MW = $clog2(M);
  localparam int KW = $clog2(K);
  localparam int NW = $clog2(N);
  localparam int DW = DATA_WIDTH_INIT_MATRIX;

  // Control and status
  logic            start;
  logic            busy;
  logic            fetch_done;

  // Operand memory read port (data returns one cycle after the strobe)
  logic            rd_en_a;
  logic            rd_en_b;
  logic [MW-1:0]   addr_a_row;
  logic [KW-1:0]   addr_a_col;
  logic [KW-1:0]   addr_b_row;
  logic [NW-1:0]   addr_b_col;
  logic [DW-1:0]   data_a;
  logic [DW-1:0]   data_b;

  // Product stream towards the accumulator
  logic [2*DW-1:0] product_reg;
  logic [MW-1:0]   matrix_a_row_addr_counter_reg;
  logic [KW-1:0]   matrix_a_col_addr_counter_reg;
  logic [KW-1:0]   matrix_b_row_addr_counter_reg;
  logic [NW-1:0]   matrix_b_col_addr_counter_reg;
  logic            mult_done_reg;

  modport master (
    input  start, data_a, data_b,
    output busy, fetch_done,
    output rd_en_a, rd_en_b, addr_a_row, addr_a_col, addr_b_row, addr_b_col,
    output product_reg, matrix_a_row_addr_counter_reg,
           matrix_a_col_addr_counter_reg, matrix_b_row_addr_counter_reg,
           matrix_b_col_addr_counter_reg, mult_done_reg
  );

  modport slave (
    output start, data_a, data_b,
    input  busy, fetch_done,
    input  rd_en_a, rd_en_b, addr_a_row, addr_a_col, addr_b_row, addr_b_col,
    input  product_reg, matrix_a_row_addr_counter_reg,
           matrix_a_col_addr_counter_reg, matrix_b_row_addr_counter_reg,
           matrix_b_col_addr_counter_reg, mult_done_reg
  );
endinterface

// File: rtl/mac_mult_fetch.sv
// mac_mult_fetch: operand fetch and multiply stage for C = A x B.
// On start it walks (i, j, k) with k innermost, reads A[i][k] and B[k][j],
// and emits one full-width registered product per cycle together with its
// indices, in the order mac_stop_accum accumulates them.
// Optional feature: define MAC_MULT_SIGNED_EN for a two's complement multiply;
// the default build multiplies unsigned (zero-extended) operands.
module mac_mult_fetch #(
  parameter int M                      = 4,
  parameter int K                      = 4,
  parameter int N                      = 4,
  parameter int DATA_WIDTH_INIT_MATRIX = 32
) (
  input logic            clk,
  input logic            reset,
  mac_mult_fetch_if.master bus
);

  localparam int MW = $clog2(M);
  localparam int KW = $clog2(K);
  localparam int NW = $clog2(N);
  localparam int DW = DATA_WIDTH_INIT_MATRIX;
  localparam int PW = 2 * DW;

  localparam logic [MW-1:0] I_LAST = MW'(M - 1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [NW-1:0] J_LAST = NW'(N - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [MW-1:0] idx_i;
  logic [NW-1:0] idx_j;
  logic [KW-1:0] idx_k;
  logic          drain_cnt;

  logic          issue;
  logic          last_issue;

  // Stage 1: indices of the read currently in flight
  logic          s1_valid;
  logic [MW-1:0] s1_i;
  logic [NW-1:0] s1_j;
  logic [KW-1:0] s1_k;

  // Full-width operands so the product is never truncated
  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] mult_full;

  assign issue      = (state == RUN);
  assign last_issue = issue && (idx_i == I_LAST) && (idx_j == J_LAST) &&
                      (idx_k == K_LAST);

  // Read port: addresses come straight from the index registers
  assign bus.rd_en_a    = issue;
  assign bus.rd_en_b    = issue;
  assign bus.addr_a_row = idx_i;
  assign bus.addr_a_col = idx_k;
  assign bus.addr_b_row = idx_k;
  assign bus.addr_b_col = idx_j;

  assign bus.busy       = (state == RUN) || (state == DRAIN);
  assign bus.fetch_done = (state == DONE);

`ifdef MAC_MULT_SIGNED_EN
  // Sign-extend so the low PW bits of the product are the signed result
  assign a_ext = {{DW{bus.data_a[DW-1]}}, bus.data_a};
  assign b_ext = {{DW{bus.data_b[DW-1]}}, bus.data_b};
`else
  assign a_ext = {{DW{1'b0}}, bus.data_a};
  assign b_ext = {{DW{1'b0}}, bus.data_b};
`endif

  assign mult_full = a_ext * b_ext;

  // Sequencer: FSM plus the (i, j, k) walk, k innermost and i outermost
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, matching real flip-flop behaviour.
    if (reset) begin
      state     <= IDLE;
      idx_i     <= '0;
      idx_j     <= '0;
      idx_k     <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= RUN;
            idx_i <= '0;
            idx_j <= '0;
            idx_k <= '0;
          end
        end
        RUN: begin
          if (last_issue) begin
            // Indices hold their final values while the pipeline drains
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end else if (idx_k != K_LAST) begin
            idx_k <= idx_k + 1'b1;
          end else begin
            idx_k <= '0;
            if (idx_j != J_LAST) begin
              idx_j <= idx_j + 1'b1;
            end else begin
              idx_j <= '0;
              idx_i <= idx_i + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Two cycles: one for the memory read, one for the multiply
          if (drain_cnt) begin
            state <= DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stage 1: track the issued indices while the memory read is in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_i     <= '0;
      s1_j     <= '0;
      s1_k     <= '0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        s1_i <= idx_i;
        s1_j <= idx_j;
        s1_k <= idx_k;
      end
    end
  end

  // Stage 2: register the product and its indices; hold them when idle
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset too, because downstream logic
    // expects product and counter outputs to read zero after reset.
    if (reset) begin
      bus.mult_done_reg                 <= 1'b0;
      bus.product_reg                   <= '0;
      bus.matrix_a_row_addr_counter_reg <= '0;
      bus.matrix_a_col_addr_counter_reg <= '0;
      bus.matrix_b_row_addr_counter_reg <= '0;
      bus.matrix_b_col_addr_counter_reg <= '0;
    end else begin
      bus.mult_done_reg <= s1_valid;
      if (s1_valid) begin
        bus.product_reg                   <= mult_full;
        bus.matrix_a_row_addr_counter_reg <= s1_i;
        bus.matrix_a_col_addr_counter_reg <= s1_k;
        bus.matrix_b_row_addr_counter_reg <= s1_k;
        bus.matrix_b_col_addr_counter_reg <= s1_j;
      end
    end
  end

endmodule

// File: tb/tb_mac_mult_fetch.sv
// tb_mac_mult_fetch: scoreboard bench for mac_mult_fetch. Each pass pushes
// the expected product stream (indices, value, cycle) into a queue; a monitor
// pops and compares whenever mult_done_reg or fetch_done is seen.
module tb_mac_mult_fetch;

  localparam int M   = 4;
  localparam int K   = 4;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int PW  = 64;
  localparam int MNK = M * N * K;

  typedef struct {
    int            i;
    int            j;
    int            k;
    logic [PW-1:0] prod;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t exp_q[$];
  int   fd_q[$];

  logic [DW-1:0] mem_a [M][K];
  logic [DW-1:0] mem_b [K][N];

  mac_mult_fetch_if #(.M(M), .K(K), .N(N), .DATA_WIDTH_INIT_MATRIX(DW)) bus ();

  mac_mult_fetch #(.M(M), .K(K), .N(N), .DATA_WIDTH_INIT_MATRIX(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read operand memories: data valid the cycle after the strobe
  always @(posedge clk) begin
    if (bus.rd_en_a) bus.data_a <= mem_a[bus.addr_a_row][bus.addr_a_col];
    if (bus.rd_en_b) bus.data_b <= mem_b[bus.addr_b_row][bus.addr_b_col];
  end

  task automatic check(input string name, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
`ifdef MAC_MULT_SIGNED_EN
    logic signed [PW-1:0] sa;
    logic signed [PW-1:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
`else
    logic [PW-1:0] ua;
    logic [PW-1:0] ub;
    ua = a;
    ub = b;
    return ua * ub;
`endif
  endfunction

  // Reference stream: i outer, j middle, k inner, one product per cycle
  task automatic push_pass(input int c0);
    int n = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < K; k++) begin
          exp_t e;
          e.i    = i;
          e.j    = j;
          e.k    = k;
          e.prod = ref_mul(mem_a[i][k], mem_b[k][j]);
          e.cyc  = c0 + 2 + n;
          exp_q.push_back(e);
          n++;
        end
    fd_q.push_back(c0 + 2 + MNK);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},       bus.busy, 0);
    check({tag, "_rd_en_a"},    bus.rd_en_a, 0);
    check({tag, "_rd_en_b"},    bus.rd_en_b, 0);
    check({tag, "_mult_done"},  bus.mult_done_reg, 0);
    check({tag, "_fetch_done"}, bus.fetch_done, 0);
    check({tag, "_product"},    bus.product_reg, 0);
    check({tag, "_cnt_i"},      bus.matrix_a_row_addr_counter_reg, 0);
    check({tag, "_cnt_ka"},     bus.matrix_a_col_addr_counter_reg, 0);
    check({tag, "_cnt_kb"},     bus.matrix_b_row_addr_counter_reg, 0);
    check({tag, "_cnt_j"},      bus.matrix_b_col_addr_counter_reg, 0);
    check({tag, "_addr"}, {bus.addr_a_row, bus.addr_a_col, bus.addr_b_row, bus.addr_b_col}, 0);
  endtask

  // pattern: 0 A=1/B=2, 1 A=i+k+1/B=1, 2 A=0xFFFFFFFD/B=5, 3 random
  task automatic fill(input int pattern);
    for (int i = 0; i < M; i++)
      for (int k = 0; k < K; k++)
        case (pattern)
          0:       mem_a[i][k] = 32'd1;
          1:       mem_a[i][k] = DW'(i + k + 1);
          2:       mem_a[i][k] = 32'hFFFF_FFFD;
          default: mem_a[i][k] = $urandom();
        endcase
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++)
        case (pattern)
          0:       mem_b[k][j] = 32'd2;
          1:       mem_b[k][j] = 32'd1;
          2:       mem_b[k][j] = 32'd5;
          default: mem_b[k][j] = $urandom();
        endcase
  endtask

  // Runs one or more passes from IDLE; poke pulses start mid-RUN and in DONE,
  // passes > 1 holds start across DONE to chain back-to-back passes.
  task automatic run_pass(input bit poke, input int passes);
    int c0;
    int f;
    c0 = cyc + 1;
    f  = c0 + 2 + MNK;
    push_pass(c0);
    bus.start = 1'b1;
    for (int p = 0; p < passes; p++) begin
      f = c0 + 2 + MNK;
      wait_cyc(c0);
      bus.start = 1'b0;
      check("first_busy",  bus.busy, 1);
      check("first_rd_en", {bus.rd_en_a, bus.rd_en_b}, 2'b11);
      check("first_addr",  {bus.addr_a_row, bus.addr_a_col, bus.addr_b_row, bus.addr_b_col}, 0);
      if (poke) begin
        wait_cyc(c0 + 30);
        bus.start = 1'b1;
        wait_cyc(c0 + 31);
        bus.start = 1'b0;
      end
      wait_cyc(f - 1);
      check("busy_last_drain", bus.busy, 1);
      wait_cyc(f);
      check("busy_at_done", bus.busy, 0);
      if (poke || (p + 1 < passes)) bus.start = 1'b1;
      if (p + 1 < passes) begin
        c0 = f + 2;
        push_pass(c0);
      end else if (poke) begin
        wait_cyc(f + 1);
        bus.start = 1'b0;
      end
    end
    wait_cyc(f + 4);
    check("idle_after_pass", bus.busy, 0);
    check("products_outstanding", exp_q.size(), 0);
    check("fetch_done_outstanding", fd_q.size(), 0);
  endtask

  // Monitor: compare every presented product and fetch_done to the scoreboard
  initial begin : monitor
    exp_t e;
    int   fd;
    forever begin
      @(negedge clk);
      if (bus.mult_done_reg === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_product", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("product",      bus.product_reg, e.prod);
          check("cnt_i",        bus.matrix_a_row_addr_counter_reg, e.i);
          check("cnt_j",        bus.matrix_b_col_addr_counter_reg, e.j);
          check("cnt_a_col",    bus.matrix_a_col_addr_counter_reg, e.k);
          check("cnt_b_row",    bus.matrix_b_row_addr_counter_reg, e.k);
          check("product_cycle", cyc, e.cyc);
        end
      end
      if (bus.fetch_done === 1'b1) begin
        if (fd_q.size() == 0) begin
          check("unexpected_fetch_done", 1, 0);
        end else begin
          fd = fd_q.pop_front();
          check("fetch_done_cycle", cyc, fd);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int c0;
    reset     = 1'b1;
    bus.start = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    fill(0);
    run_pass(1'b0, 1);
    fill(1);
    run_pass(1'b0, 1);
    fill(2);
    run_pass(1'b0, 1);
    fill(3);
    run_pass(1'b1, 1);
    fill(3);
    run_pass(1'b0, 2);

    // Reset on the 20th RUN cycle discards the pass, then restart cleanly
    fill(3);
    c0 = cyc + 1;
    push_pass(c0);
    bus.start = 1'b1;
    wait_cyc(c0);
    bus.start = 1'b0;
    wait_cyc(c0 + 19);
    reset = 1'b1;
    wait_cyc(c0 + 20);
    exp_q.delete();
    fd_q.delete();
    check_zero("mid_reset");
    reset = 1'b0;
    @(negedge clk);
    run_pass(1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
